// File: rtl/decode_stage.sv
// Registered instruction-decode stage: field split, ID/EX register, destination scoreboard.
// Define DECODE_FWD_EN to forward writeback data into the source operands and bypass their hazard.
module decode_stage #(
   parameter int DATA_W     = 8,
   parameter int REG_ADDR_W = 2,
   parameter int OPCODE_W   = 4,
   parameter int RSVD_W     = 4,
   parameter int NOP_OPCODE = 0,
   localparam int INSTR_W   = OPCODE_W + 3*REG_ADDR_W + RSVD_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [INSTR_W-1:0]    i_instructions,
   output logic [REG_ADDR_W-1:0] o_rf_rd1_addr,
   output logic [REG_ADDR_W-1:0] o_rf_rd2_addr,
   input  logic [DATA_W-1:0]     i_reg1_read_data,
   input  logic [DATA_W-1:0]     i_reg2_read_data,
   input  logic                  i_wb_en,
   input  logic [REG_ADDR_W-1:0] i_wb_addr,
   input  logic [DATA_W-1:0]     i_wb_data,
   input  logic                  i_flush,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [OPCODE_W-1:0]   o_opcode,
   output logic [REG_ADDR_W-1:0] o_reg0_addr,
   output logic [REG_ADDR_W-1:0] o_reg1_addr,
   output logic [REG_ADDR_W-1:0] o_reg2_addr,
   output logic [RSVD_W-1:0]     o_reserved,
   output logic [DATA_W-1:0]     o_operand0,
   output logic [DATA_W-1:0]     o_operand1
);

   localparam int NUM_REGS = 2**REG_ADDR_W;
   localparam logic [OPCODE_W-1:0] NOP_OP = OPCODE_W'(NOP_OPCODE);

   logic [OPCODE_W-1:0]   in_op;
   logic [REG_ADDR_W-1:0] in_r0, in_r1, in_r2;
   logic [RSVD_W-1:0]     in_rsvd;
   logic                  fwd1, fwd2, hazard, accept, drain;

   logic                  valid_q, valid_d;
   logic [OPCODE_W-1:0]   opcode_q, opcode_d;
   logic [REG_ADDR_W-1:0] reg0_q, reg0_d, reg1_q, reg1_d, reg2_q, reg2_d;
   logic [RSVD_W-1:0]     rsvd_q, rsvd_d;
   logic [DATA_W-1:0]     operand0_q, operand0_d, operand1_q, operand1_d;
   logic [NUM_REGS-1:0]   pending_q, pending_d;

   assign {in_op, in_r0, in_r1, in_r2, in_rsvd} = i_instructions;
   assign o_rf_rd1_addr = in_r1;
   assign o_rf_rd2_addr = in_r2;

`ifdef DECODE_FWD_EN
   assign fwd1 = i_wb_en && (i_wb_addr == in_r1);
   assign fwd2 = i_wb_en && (i_wb_addr == in_r2);
`else
   logic wb_data_unused;
   assign wb_data_unused = ^i_wb_data;
   assign fwd1 = 1'b0;
   assign fwd2 = 1'b0;
`endif

   // Destination is only checked for WAW; forwarding never bypasses it.
   assign hazard  = (pending_q[in_r1] && !fwd1) ||
                    (pending_q[in_r2] && !fwd2) ||
                    ((in_op != NOP_OP) && pending_q[in_r0]);
   assign o_ready = (!valid_q || i_ready) && !hazard && !i_flush;
   assign accept  = i_valid && o_ready;
   assign drain   = valid_q && i_ready;

   always_comb begin
      valid_d    = valid_q;
      opcode_d   = opcode_q;
      reg0_d     = reg0_q;
      reg1_d     = reg1_q;
      reg2_d     = reg2_q;
      rsvd_d     = rsvd_q;
      operand0_d = operand0_q;
      operand1_d = operand1_q;
      if (i_flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d    = 1'b1;
         opcode_d   = in_op;
         reg0_d     = in_r0;
         reg1_d     = in_r1;
         reg2_d     = in_r2;
         rsvd_d     = in_rsvd;
         operand0_d = fwd1 ? i_wb_data : i_reg1_read_data;
         operand1_d = fwd2 ? i_wb_data : i_reg2_read_data;
      end else if (drain) begin
         valid_d = 1'b0;
      end
   end

   // Set is applied last so it wins over a same-cycle clear.
   always_comb begin
      pending_d = pending_q;
      if (i_wb_en)
         pending_d[i_wb_addr] = 1'b0;
      if (i_flush && valid_q && (opcode_q != NOP_OP))
         pending_d[reg0_q] = 1'b0;
      if (accept && (in_op != NOP_OP))
         pending_d[in_r0] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_q    <= 1'b0;
         opcode_q   <= '0;
         reg0_q     <= '0;
         reg1_q     <= '0;
         reg2_q     <= '0;
         rsvd_q     <= '0;
         operand0_q <= '0;
         operand1_q <= '0;
         pending_q  <= '0;
      end else begin
         valid_q    <= valid_d;
         opcode_q   <= opcode_d;
         reg0_q     <= reg0_d;
         reg1_q     <= reg1_d;
         reg2_q     <= reg2_d;
         rsvd_q     <= rsvd_d;
         operand0_q <= operand0_d;
         operand1_q <= operand1_d;
         pending_q  <= pending_d;
      end
   end

   assign o_valid     = valid_q;
   assign o_opcode    = opcode_q;
   assign o_reg0_addr = reg0_q;
   assign o_reg1_addr = reg1_q;
   assign o_reg2_addr = reg2_q;
   assign o_reserved  = rsvd_q;
   assign o_operand0  = operand0_q;
   assign o_operand1  = operand1_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed vector bench for decode_stage (default parameters); expectations adapt to DECODE_FWD_EN.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [13:0] i_instructions;
   logic [1:0]  o_rf_rd1_addr, o_rf_rd2_addr;
   logic [7:0]  i_reg1_read_data, i_reg2_read_data;
   logic        i_wb_en;
   logic [1:0]  i_wb_addr;
   logic [7:0]  i_wb_data;
   logic        i_flush;
   logic        o_valid;
   logic        i_ready;
   logic [3:0]  o_opcode;
   logic [1:0]  o_reg0_addr, o_reg1_addr, o_reg2_addr;
   logic [3:0]  o_reserved;
   logic [7:0]  o_operand0, o_operand1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .reset(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_instructions(i_instructions), .o_rf_rd1_addr(o_rf_rd1_addr),
      .o_rf_rd2_addr(o_rf_rd2_addr), .i_reg1_read_data(i_reg1_read_data),
      .i_reg2_read_data(i_reg2_read_data), .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr),
      .i_wb_data(i_wb_data), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
      .o_opcode(o_opcode), .o_reg0_addr(o_reg0_addr), .o_reg1_addr(o_reg1_addr),
      .o_reg2_addr(o_reg2_addr), .o_reserved(o_reserved),
      .o_operand0(o_operand0), .o_operand1(o_operand1)
   );

   typedef struct {
      string       name;
      logic        rst_n;
      logic        valid;
      logic [13:0] instr;
      logic [7:0]  rd1, rd2;
      logic        wb_en;
      logic [1:0]  wb_addr;
      logic [7:0]  wb_data;
      logic        flush;
      logic        rdy;
      logic        exp_ready;
      logic        exp_valid;
      logic [13:0] exp_fields;
      logic [7:0]  exp_op0, exp_op1;
   } vec_t;

   function automatic logic [13:0] mk(input logic [3:0] op, input logic [1:0] r0, r1, r2,
                                      input logic [3:0] rs);
      return {op, r0, r1, r2, rs};
   endfunction

   function automatic vec_t mv(input string n, input logic rst, vld, input logic [13:0] ins,
                               input logic [7:0] d1, d2, input logic wbe, input logic [1:0] wba,
                               input logic [7:0] wbd, input logic fl, rdy, er, ev,
                               input logic [13:0] ef, input logic [7:0] e0, e1);
      vec_t v;
      v.name = n; v.rst_n = rst; v.valid = vld; v.instr = ins; v.rd1 = d1; v.rd2 = d2;
      v.wb_en = wbe; v.wb_addr = wba; v.wb_data = wbd; v.flush = fl; v.rdy = rdy;
      v.exp_ready = er; v.exp_valid = ev; v.exp_fields = ef; v.exp_op0 = e0; v.exp_op1 = e1;
      return v;
   endfunction

   task automatic chk(input string n, input string what, input logic [31:0] act, exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s/%s: got %0h expected %0h", n, what, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      logic [1:0] e_rd1, e_rd2;
      @(negedge clk);
      rst_n = v.rst_n; i_valid = v.valid; i_instructions = v.instr;
      i_reg1_read_data = v.rd1; i_reg2_read_data = v.rd2;
      i_wb_en = v.wb_en; i_wb_addr = v.wb_addr; i_wb_data = v.wb_data;
      i_flush = v.flush; i_ready = v.rdy;
      e_rd1 = v.instr[7:6];
      e_rd2 = v.instr[5:4];
      #1;
      chk(v.name, "o_ready", 32'(o_ready), 32'(v.exp_ready));
      chk(v.name, "rd1_addr", 32'(o_rf_rd1_addr), 32'(e_rd1));
      chk(v.name, "rd2_addr", 32'(o_rf_rd2_addr), 32'(e_rd2));
      @(posedge clk);
      #1;
      chk(v.name, "o_valid", 32'(o_valid), 32'(v.exp_valid));
      chk(v.name, "fields", 32'({o_opcode, o_reg0_addr, o_reg1_addr, o_reg2_addr, o_reserved}),
          32'(v.exp_fields));
      chk(v.name, "operand0", 32'(o_operand0), 32'(v.exp_op0));
      chk(v.name, "operand1", 32'(o_operand1), 32'(v.exp_op1));
   endtask

   vec_t vq[$];
   logic [13:0] i1, i2, inop, ird2, iflsh, ird3, iself, iwaw, iw1, iraw, ird1;

   initial begin
      i1    = mk(4'd3, 2'd1, 2'd2, 2'd3, 4'd5);
      i2    = mk(4'd4, 2'd2, 2'd0, 2'd3, 4'd7);
      inop  = mk(4'd0, 2'd2, 2'd0, 2'd1, 4'd0);
      ird2  = mk(4'd5, 2'd3, 2'd2, 2'd2, 4'd1);
      iflsh = mk(4'd6, 2'd0, 2'd1, 2'd2, 4'd0);
      ird3  = mk(4'd7, 2'd0, 2'd3, 2'd3, 4'd2);
      iself = mk(4'd8, 2'd1, 2'd1, 2'd2, 4'd0);
      iwaw  = mk(4'd9, 2'd0, 2'd2, 2'd2, 4'd0);
      iw1   = mk(4'd1, 2'd1, 2'd0, 2'd0, 4'd0);
      iraw  = mk(4'd2, 2'd2, 2'd1, 2'd3, 4'd0);
      ird1  = mk(4'd3, 2'd0, 2'd1, 2'd1, 4'd0);

      //        name        rst vld instr  rd1    rd2    wbe wba   wbd    fl  rdy er  ev  fields  op0    op1
      vq.push_back(mv("reset",    0, 0, 14'h0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 0, 1, 1, 0, 14'h0, 8'h00, 8'h00));
      vq.push_back(mv("basic",    1, 1, i1,    8'hA0, 8'h0B, 0, 2'd0, 8'h00, 0, 1, 1, 1, 14'h0DB5, 8'hA0, 8'h0B));
      vq.push_back(mv("bp0",      1, 1, i2,    8'h11, 8'h22, 0, 2'd0, 8'h00, 0, 0, 0, 1, i1,    8'hA0, 8'h0B));
      vq.push_back(mv("bp1",      1, 1, i2,    8'h11, 8'h22, 0, 2'd0, 8'h00, 0, 0, 0, 1, i1,    8'hA0, 8'h0B));
      vq.push_back(mv("bp2",      1, 1, i2,    8'h11, 8'h22, 0, 2'd0, 8'h00, 0, 0, 0, 1, i1,    8'hA0, 8'h0B));
      vq.push_back(mv("bp_rel",   1, 1, i2,    8'h11, 8'h22, 0, 2'd0, 8'h00, 0, 1, 1, 1, i2,    8'h11, 8'h22));
      vq.push_back(mv("wb2",      1, 0, 14'h0, 8'h00, 8'h00, 1, 2'd2, 8'h00, 0, 1, 1, 0, i2,    8'h11, 8'h22));
      vq.push_back(mv("wb1",      1, 0, 14'h0, 8'h00, 8'h00, 1, 2'd1, 8'h00, 0, 1, 1, 0, i2,    8'h11, 8'h22));
      vq.push_back(mv("nop",      1, 1, inop,  8'h33, 8'h44, 0, 2'd0, 8'h00, 0, 1, 1, 1, inop,  8'h33, 8'h44));
      vq.push_back(mv("after_nop",1, 1, ird2,  8'h66, 8'h77, 0, 2'd0, 8'h00, 0, 1, 1, 1, ird2,  8'h66, 8'h77));
      vq.push_back(mv("flush",    1, 1, iflsh, 8'h00, 8'h00, 0, 2'd0, 8'h00, 1, 0, 0, 0, ird2,  8'h66, 8'h77));
      vq.push_back(mv("post_fl",  1, 1, ird3,  8'h88, 8'h99, 0, 2'd0, 8'h00, 0, 1, 1, 1, ird3,  8'h88, 8'h99));
      vq.push_back(mv("self_src", 1, 1, iself, 8'hAA, 8'hBB, 0, 2'd0, 8'h00, 0, 1, 1, 1, iself, 8'hAA, 8'hBB));
      vq.push_back(mv("waw0",     1, 1, iwaw,  8'hCC, 8'hDD, 0, 2'd0, 8'h00, 0, 1, 0, 0, iself, 8'hAA, 8'hBB));
      vq.push_back(mv("waw_wb",   1, 1, iwaw,  8'hCC, 8'hDD, 1, 2'd0, 8'h00, 0, 1, 0, 0, iself, 8'hAA, 8'hBB));
      vq.push_back(mv("waw_go",   1, 1, iwaw,  8'hCC, 8'hDD, 0, 2'd0, 8'h00, 0, 1, 1, 1, iwaw,  8'hCC, 8'hDD));
      // RAW on r1: stall until writeback of r1
      vq.push_back(mv("raw_rst",  0, 0, 14'h0, 8'h00, 8'h00, 0, 2'd0, 8'h00, 0, 1, 0, 0, 14'h0, 8'h00, 8'h00));
      vq.push_back(mv("raw_prod", 1, 1, iw1,   8'h12, 8'h34, 0, 2'd0, 8'h00, 0, 1, 1, 1, iw1,   8'h12, 8'h34));
      vq.push_back(mv("raw_st0",  1, 1, iraw,  8'hEE, 8'hCC, 0, 2'd0, 8'h00, 0, 1, 0, 0, iw1,   8'h12, 8'h34));
      vq.push_back(mv("raw_st1",  1, 1, iraw,  8'hEE, 8'hCC, 0, 2'd0, 8'h00, 0, 1, 0, 0, iw1,   8'h12, 8'h34));
`ifdef DECODE_FWD_EN
      vq.push_back(mv("raw_wb",   1, 1, iraw,  8'hEE, 8'hCC, 1, 2'd1, 8'h55, 0, 1, 1, 1, iraw,  8'h55, 8'hCC));
`else
      vq.push_back(mv("raw_wb",   1, 1, iraw,  8'hEE, 8'hCC, 1, 2'd1, 8'h55, 0, 1, 0, 0, iw1,   8'h12, 8'h34));
      vq.push_back(mv("raw_go",   1, 1, iraw,  8'hEE, 8'hCC, 0, 2'd0, 8'h00, 0, 1, 1, 1, iraw,  8'hEE, 8'hCC));
`endif
      // reset in the middle of a hazard stall
      vq.push_back(mv("ms_prod",  1, 1, iw1,   8'h01, 8'h02, 0, 2'd0, 8'h00, 0, 1, 1, 1, iw1,   8'h01, 8'h02));
      vq.push_back(mv("ms_stall", 1, 1, ird1,  8'h03, 8'h04, 0, 2'd0, 8'h00, 0, 1, 0, 0, iw1,   8'h01, 8'h02));
      vq.push_back(mv("ms_reset", 0, 1, ird1,  8'h03, 8'h04, 0, 2'd0, 8'h00, 0, 1, 0, 0, 14'h0, 8'h00, 8'h00));
      vq.push_back(mv("ms_after", 1, 1, ird1,  8'h5A, 8'hA5, 0, 2'd0, 8'h00, 0, 1, 1, 1, ird1,  8'h5A, 8'hA5));

      rst_n = 1'b0; i_valid = 1'b0; i_instructions = '0;
      i_reg1_read_data = '0; i_reg2_read_data = '0;
      i_wb_en = 1'b0; i_wb_addr = '0; i_wb_data = '0; i_flush = 1'b0; i_ready = 1'b1;
      repeat (2) @(posedge clk);

      foreach (vq[k]) apply(vq[k]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
